// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified I/D memory between fetch (read-only) and the memory stage.
// Latency: grant is combinational in the request cycle; read data returns MEM_LATENCY cycles after the grant.
// Backpressure: requesters hold req until gnt; only one read may be outstanding, so new grants happen when idle or when read data returns.
// Ports: clk/reset (async, active-high); if_* fetch port; dm_* load/store port; mem_* memory macro; if_stall/dm_stall to hazard unit.
// Config: define MEM_ARB_RR_EN to alternate between requesters on simultaneous requests (default: fixed dm priority).
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [3:0]            dm_be,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  if_stall,
  output logic                  dm_stall
);

  typedef enum logic {IDLE, WAIT} arbState;

  // Counter is preloaded with LATENCY-1 so that cnt==0 in WAIT marks the data-return cycle.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  arbState               state;
  logic [3:0]            cnt;
  logic                  ownerDm;
  logic [DATA_WIDTH-1:0] ifRdataQ;
  logic [DATA_WIDTH-1:0] dmRdataQ;
  logic                  rdDone;
  logic                  opportunity;
  logic                  pickDm;
  logic                  anyGnt;
  logic                  grantRead;

  assign rdDone      = (state == WAIT) && (cnt == 4'd0);
  // The data-return cycle doubles as a grant slot, giving one read per MEM_LATENCY cycles.
  assign opportunity = (state == IDLE) || rdDone;

`ifdef MEM_ARB_RR_EN
  logic lastGntDm;
  // On a tie the requester that did not win last time goes first.
  assign pickDm = dm_req && (!if_req || !lastGntDm);
`else
  assign pickDm = dm_req;
`endif

  // Grants are masked during reset so every output reads zero while reset is high.
  assign anyGnt    = opportunity && !reset && (if_req || dm_req);
  assign dm_gnt    = anyGnt && pickDm;
  assign if_gnt    = anyGnt && !pickDm;
  assign grantRead = if_gnt || (dm_gnt && !dm_we);

  assign mem_req   = anyGnt;
  assign mem_we    = dm_gnt && dm_we;
  assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = (dm_gnt && dm_we) ? dm_wdata : '0;
  assign mem_be    = dm_gnt ? dm_be : 4'b0000;

  assign if_rvalid = rdDone && !ownerDm;
  assign dm_rvalid = rdDone && ownerDm;
  // Read data passes straight through on the pulse and is held afterwards.
  assign if_rdata  = if_rvalid ? mem_rdata : ifRdataQ;
  assign dm_rdata  = dm_rvalid ? mem_rdata : dmRdataQ;

  assign if_stall  = !reset && if_req && !if_gnt;
  assign dm_stall  = !reset && ((dm_req && !dm_gnt) || ((state == WAIT) && ownerDm && !dm_rvalid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ownerDm  <= 1'b0;
      ifRdataQ <= '0;
      dmRdataQ <= '0;
    end else begin
      if (if_rvalid) ifRdataQ <= mem_rdata;
      if (dm_rvalid) dmRdataQ <= mem_rdata;
      if (opportunity) begin
        if (grantRead) begin
          state   <= WAIT;
          cnt     <= CNT_INIT;
          ownerDm <= dm_gnt;
        end else begin
          // Stores finish in their grant cycle; no request also lands here.
          state <= IDLE;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGntDm <= 1'b0;
    end else if (anyGnt) begin
      lastGntDm <= dm_gnt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LATENCY 2 and 1) driven with directed and random traffic.
// Reference model tracks the outstanding read as an absolute due cycle number.
// Build with MEM_ARB_RR_EN defined to check the alternating-grant variant.
module tb_mem_port_arbiter;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ifReq [NI], ifGnt [NI], ifRvalid [NI], ifStall [NI];
  logic        dmReq [NI], dmWe [NI], dmGnt [NI], dmRvalid [NI], dmStall [NI];
  logic        memReq [NI], memWe [NI];
  logic [31:0] ifAddr [NI], ifRdata [NI], dmAddr [NI], dmWdata [NI], dmRdata [NI];
  logic [31:0] memAddr [NI], memWdata [NI], memRdata [NI];
  logic [3:0]  dmBe [NI], memBe [NI];

  for (genvar g = 0; g < NI; g++) begin : gDut
    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(g == 0 ? 2 : 1)) dut (
      .clk(clk), .reset(rst),
      .if_req(ifReq[g]), .if_addr(ifAddr[g]), .if_gnt(ifGnt[g]), .if_rvalid(ifRvalid[g]), .if_rdata(ifRdata[g]),
      .dm_req(dmReq[g]), .dm_we(dmWe[g]), .dm_addr(dmAddr[g]), .dm_wdata(dmWdata[g]), .dm_be(dmBe[g]),
      .dm_gnt(dmGnt[g]), .dm_rvalid(dmRvalid[g]), .dm_rdata(dmRdata[g]),
      .mem_req(memReq[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]), .mem_wdata(memWdata[g]), .mem_be(memBe[g]),
      .mem_rdata(memRdata[g]), .if_stall(ifStall[g]), .dm_stall(dmStall[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int now   = 0;

  // Reference model: outstanding read (due cycle, -1 = none), held read data, tie-break history.
  int          due [NI];
  bit          ownDm [NI];
  logic [31:0] rdA [NI];
  logic [31:0] ifHeld [NI], dmHeld [NI];
  bit          lastDm [NI];
  // Requester behaviour: pending request fields, held until granted.
  bit          ifP [NI], dmP [NI], dmW [NI];
  logic [31:0] ifA [NI], dmA [NI], dmD [NI];
  logic [3:0]  dmB [NI];
  logic [31:0] ifQ [NI][$];
  bit          rnd = 0;
  bit          useFixed = 0;
  logic [31:0] fixedData = 32'hDEADBEEF;
  // Observations of the DUT.
  int          lastIfGnt [NI], lastDmGnt [NI], lastIfRv [NI], lastDmRv [NI];
  logic [31:0] obsIfData [NI], obsIfAddr, obsWdata;
  logic        obsWe;
  logic [3:0]  obsBe;
  bit          gntSeq [$];
  int          l1Gnt [$], l1Rv [$];
  logic [31:0] l1Addr [$], l1Data [$];

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] dueData(input int k);
    return useFixed ? fixedData : memData(rdA[k]);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NI; k++) begin
      due[k] = -1; ownDm[k] = 0; ifHeld[k] = '0; dmHeld[k] = '0; lastDm[k] = 0;
      ifP[k] = 0; dmP[k] = 0;
      ifReq[k] = 0; dmReq[k] = 0; dmWe[k] = 0; ifAddr[k] = '0; dmAddr[k] = '0;
      dmWdata[k] = '0; dmBe[k] = '0; memRdata[k] = '0;
    end
  endtask

  // One clock cycle on both instances, every output checked against the model.
  task automatic step();
    bit dueNow, opp, wDm, gI, gD;
    logic [31:0] eIfD, eDmD;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      if (!ifP[k] && ifQ[k].size() > 0) begin ifP[k] = 1; ifA[k] = ifQ[k].pop_front(); end
      if (rnd) begin
        if (!ifP[k] && $urandom_range(0, 99) < 40) begin ifP[k] = 1; ifA[k] = 32'($urandom_range(0, 1023)) << 2; end
        if (!dmP[k] && $urandom_range(0, 99) < 40) begin
          dmP[k] = 1; dmW[k] = 1'($urandom_range(0, 1)); dmA[k] = 32'($urandom_range(0, 1023)) << 2;
          dmD[k] = $urandom; dmB[k] = 4'($urandom_range(0, 15));
        end
      end
      ifReq[k] = ifP[k]; ifAddr[k] = ifA[k];
      dmReq[k] = dmP[k]; dmWe[k] = dmW[k]; dmAddr[k] = dmA[k]; dmWdata[k] = dmD[k]; dmBe[k] = dmB[k];
      memRdata[k] = (due[k] == now) ? dueData(k) : $urandom;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      dueNow = (due[k] == now);
      opp = (due[k] < 0) || dueNow;
`ifdef MEM_ARB_RR_EN
      wDm = (dmP[k] && ifP[k]) ? !lastDm[k] : dmP[k];
`else
      wDm = dmP[k];
`endif
      gD = opp && dmP[k] && wDm;
      gI = opp && ifP[k] && !gD;
      eIfD = (dueNow && !ownDm[k]) ? dueData(k) : ifHeld[k];
      eDmD = (dueNow && ownDm[k]) ? dueData(k) : dmHeld[k];
      total++; if (ifGnt[k] !== gI) begin bad++; $display("FAIL if_gnt i%0d c%0d got=%b want=%b", k, now, ifGnt[k], gI); end
      total++; if (dmGnt[k] !== gD) begin bad++; $display("FAIL dm_gnt i%0d c%0d got=%b want=%b", k, now, dmGnt[k], gD); end
      total++; if (ifRvalid[k] !== (dueNow && !ownDm[k])) begin bad++; $display("FAIL if_rvalid i%0d c%0d got=%b want=%b", k, now, ifRvalid[k], dueNow && !ownDm[k]); end
      total++; if (dmRvalid[k] !== (dueNow && ownDm[k])) begin bad++; $display("FAIL dm_rvalid i%0d c%0d got=%b want=%b", k, now, dmRvalid[k], dueNow && ownDm[k]); end
      total++; if (ifRdata[k] !== eIfD) begin bad++; $display("FAIL if_rdata i%0d c%0d got=%h want=%h", k, now, ifRdata[k], eIfD); end
      total++; if (dmRdata[k] !== eDmD) begin bad++; $display("FAIL dm_rdata i%0d c%0d got=%h want=%h", k, now, dmRdata[k], eDmD); end
      total++; if (memReq[k] !== (gI || gD)) begin bad++; $display("FAIL mem_req i%0d c%0d got=%b want=%b", k, now, memReq[k], gI || gD); end
      total++; if (memWe[k] !== (gD && dmW[k])) begin bad++; $display("FAIL mem_we i%0d c%0d got=%b want=%b", k, now, memWe[k], gD && dmW[k]); end
      if (gI || gD) begin
        total++; if (memAddr[k] !== (gD ? dmA[k] : ifA[k])) begin bad++; $display("FAIL mem_addr i%0d c%0d got=%h want=%h", k, now, memAddr[k], gD ? dmA[k] : ifA[k]); end
      end
      if (gD && dmW[k]) begin
        total++; if (memWdata[k] !== dmD[k]) begin bad++; $display("FAIL mem_wdata i%0d c%0d got=%h want=%h", k, now, memWdata[k], dmD[k]); end
        total++; if (memBe[k] !== dmB[k]) begin bad++; $display("FAIL mem_be i%0d c%0d got=%b want=%b", k, now, memBe[k], dmB[k]); end
      end
      total++; if (ifStall[k] !== (ifP[k] && !gI)) begin bad++; $display("FAIL if_stall i%0d c%0d got=%b want=%b", k, now, ifStall[k], ifP[k] && !gI); end
      total++; if (dmStall[k] !== ((dmP[k] && !gD) || (due[k] > now && ownDm[k]))) begin
        bad++; $display("FAIL dm_stall i%0d c%0d got=%b want=%b", k, now, dmStall[k], (dmP[k] && !gD) || (due[k] > now && ownDm[k]));
      end
      // Record what the DUT actually did.
      if (ifGnt[k] === 1'b1) begin lastIfGnt[k] = now; if (k == 0) obsIfAddr = memAddr[0]; end
      if (dmGnt[k] === 1'b1) begin lastDmGnt[k] = now; if (k == 0) begin obsWe = memWe[0]; obsBe = memBe[0]; obsWdata = memWdata[0]; end end
      if (k == 0 && (ifGnt[0] === 1'b1 || dmGnt[0] === 1'b1)) gntSeq.push_back(dmGnt[0] === 1'b1);
      if (ifRvalid[k] === 1'b1) begin lastIfRv[k] = now; obsIfData[k] = ifRdata[k]; end
      if (dmRvalid[k] === 1'b1) lastDmRv[k] = now;
      if (k == 1 && ifGnt[1] === 1'b1) begin l1Gnt.push_back(now); l1Addr.push_back(memAddr[1]); end
      if (k == 1 && ifRvalid[1] === 1'b1) begin l1Rv.push_back(now); l1Data.push_back(ifRdata[1]); end
      // Advance the model.
      if (dueNow) begin
        if (ownDm[k]) dmHeld[k] = dueData(k); else ifHeld[k] = dueData(k);
        due[k] = -1;
      end
      if (gI || (gD && !dmW[k])) begin due[k] = now + lat(k); ownDm[k] = gD; rdA[k] = gD ? dmA[k] : ifA[k]; end
      if (gI || gD) lastDm[k] = gD;
      if (gI) ifP[k] = 0;
      if (gD) dmP[k] = 0;
    end
    now++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    modelReset();
    ifReq[0] = 1'b1; dmReq[1] = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < NI; k++) begin
      total++; if (ifGnt[k] !== 1'b0 || dmGnt[k] !== 1'b0) begin bad++; $display("FAIL reset_gnt i%0d got=%b%b want=00", k, ifGnt[k], dmGnt[k]); end
      total++; if (ifRvalid[k] !== 1'b0 || dmRvalid[k] !== 1'b0) begin bad++; $display("FAIL reset_rvalid i%0d got=%b%b want=00", k, ifRvalid[k], dmRvalid[k]); end
      total++; if (memReq[k] !== 1'b0) begin bad++; $display("FAIL reset_mem_req i%0d got=%b want=0", k, memReq[k]); end
      total++; if (ifRdata[k] !== 32'h0 || dmRdata[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata i%0d got=%h/%h want=0/0", k, ifRdata[k], dmRdata[k]); end
    end
    ifReq[0] = 1'b0; dmReq[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    int start;
    useFixed = 1;
    ifP[0] = 1; ifA[0] = 32'h10;
    start = now;
    repeat (4) step();
    total++; if (lastIfGnt[0] !== start) begin bad++; $display("FAIL fetch_gnt_cycle got=%0d want=%0d", lastIfGnt[0], start); end
    total++; if (obsIfAddr !== 32'h10) begin bad++; $display("FAIL fetch_mem_addr got=%h want=00000010", obsIfAddr); end
    total++; if (lastIfRv[0] !== start + 2) begin bad++; $display("FAIL fetch_rvalid_cycle got=%0d want=%0d", lastIfRv[0], start + 2); end
    total++; if (obsIfData[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", obsIfData[0]); end
    useFixed = 0;
  endtask

  task automatic test_priority();
    int start;
    ifP[0] = 1; ifA[0] = 32'h100;
    dmP[0] = 1; dmW[0] = 0; dmA[0] = 32'h200; dmB[0] = 4'hF; dmD[0] = '0;
    start = now;
    repeat (6) step();
    total++; if (lastDmGnt[0] !== start) begin bad++; $display("FAIL prio_dm_gnt got=%0d want=%0d", lastDmGnt[0], start); end
    total++; if (lastDmRv[0] !== start + 2) begin bad++; $display("FAIL prio_dm_rvalid got=%0d want=%0d", lastDmRv[0], start + 2); end
    total++; if (lastIfGnt[0] !== start + 2) begin bad++; $display("FAIL prio_if_gnt got=%0d want=%0d", lastIfGnt[0], start + 2); end
    total++; if (lastIfRv[0] !== start + 4) begin bad++; $display("FAIL prio_if_rvalid got=%0d want=%0d", lastIfRv[0], start + 4); end
  endtask

  task automatic test_store();
    int start, prevRv;
    prevRv = lastDmRv[0];
    dmP[0] = 1; dmW[0] = 1; dmA[0] = 32'h300; dmD[0] = 32'h1234; dmB[0] = 4'b0011;
    ifP[0] = 1; ifA[0] = 32'h20;
    start = now;
    repeat (5) step();
    total++; if (lastDmGnt[0] !== start) begin bad++; $display("FAIL store_gnt got=%0d want=%0d", lastDmGnt[0], start); end
    total++; if (obsWe !== 1'b1 || obsBe !== 4'b0011) begin bad++; $display("FAIL store_we_be got=%b/%b want=1/0011", obsWe, obsBe); end
    total++; if (obsWdata !== 32'h1234) begin bad++; $display("FAIL store_wdata got=%h want=00001234", obsWdata); end
    total++; if (lastDmRv[0] !== prevRv) begin bad++; $display("FAIL store_no_rvalid got=%0d want=%0d", lastDmRv[0], prevRv); end
    total++; if (lastIfGnt[0] !== start + 1) begin bad++; $display("FAIL store_next_gnt got=%0d want=%0d", lastIfGnt[0], start + 1); end
  endtask

  task automatic test_reset_mid();
    int g, prevRv;
    ifP[0] = 1; ifA[0] = 32'h40;
    g = now;
    step();
    prevRv = lastIfRv[0];
    total++; if (lastIfGnt[0] !== g) begin bad++; $display("FAIL rstmid_gnt got=%0d want=%0d", lastIfGnt[0], g); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (ifGnt[0] !== 1'b0 || dmGnt[0] !== 1'b0 || memReq[0] !== 1'b0 || memWe[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b%b%b%b want=0000", ifGnt[0], dmGnt[0], memReq[0], memWe[0]);
    end
    total++; if (memAddr[0] !== 32'h0 || memWdata[0] !== 32'h0 || memBe[0] !== 4'h0) begin
      bad++; $display("FAIL rstmid_bus got=%h/%h/%h want=0/0/0", memAddr[0], memWdata[0], memBe[0]);
    end
    total++; if (ifRvalid[0] !== 1'b0 || dmRvalid[0] !== 1'b0 || ifStall[0] !== 1'b0 || dmStall[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_status got=%b%b%b%b want=0000", ifRvalid[0], dmRvalid[0], ifStall[0], dmStall[0]);
    end
    total++; if (ifRdata[0] !== 32'h0 || dmRdata[0] !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h/%h want=0/0", ifRdata[0], dmRdata[0]); end
    @(posedge clk); #1;
    memRdata[0] = memData(32'h40);
    @(negedge clk);
    modelReset();
    rst = 1'b0;
    repeat (4) step();
    total++; if (lastIfRv[0] !== prevRv) begin bad++; $display("FAIL rstmid_no_rvalid got=%0d want=%0d", lastIfRv[0], prevRv); end
  endtask

  task automatic test_both_continuous();
    bit expDm;
    gntSeq.delete();
    for (int i = 0; i < 12; i++) begin
      if (!ifP[0]) begin ifP[0] = 1; ifA[0] = 32'h400 + 32'(i * 4); end
      if (!dmP[0]) begin dmP[0] = 1; dmW[0] = 0; dmA[0] = 32'h800 + 32'(i * 4); dmB[0] = 4'hF; end
      step();
    end
    total++; if (gntSeq.size() < 4) begin bad++; $display("FAIL cont_grant_count got=%0d want>=4", gntSeq.size()); end
    for (int i = 0; i < gntSeq.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      expDm = (i % 2 == 0);
`else
      expDm = 1'b1;
`endif
      total++; if (gntSeq[i] !== expDm) begin bad++; $display("FAIL cont_grant_order idx%0d got_dm=%b want_dm=%b", i, gntSeq[i], expDm); end
    end
    ifP[0] = 0; dmP[0] = 0;
    repeat (3) step();
  endtask

  task automatic test_lat1_b2b();
    int start;
    l1Gnt.delete(); l1Rv.delete(); l1Addr.delete(); l1Data.delete();
    for (int i = 0; i < 4; i++) ifQ[1].push_back(32'(i * 4));
    start = now;
    repeat (7) step();
    total++; if (l1Gnt.size() != 4 || l1Rv.size() != 4) begin bad++; $display("FAIL lat1_counts got=%0d/%0d want=4/4", l1Gnt.size(), l1Rv.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < l1Gnt.size()) begin
        total++; if (l1Gnt[i] !== start + i || l1Addr[i] !== 32'(i * 4)) begin
          bad++; $display("FAIL lat1_gnt idx%0d got=c%0d/%h want=c%0d/%h", i, l1Gnt[i], l1Addr[i], start + i, 32'(i * 4));
        end
      end
      if (i < l1Rv.size()) begin
        total++; if (l1Rv[i] !== start + i + 1 || l1Data[i] !== memData(32'(i * 4))) begin
          bad++; $display("FAIL lat1_rvalid idx%0d got=c%0d/%h want=c%0d/%h", i, l1Rv[i], l1Data[i], start + i + 1, memData(32'(i * 4)));
        end
      end
    end
  endtask

  task automatic test_random();
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    for (int k = 0; k < NI; k++) begin ifP[k] = 0; dmP[k] = 0; end
    repeat (4) step();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      lastIfGnt[k] = -1; lastDmGnt[k] = -1; lastIfRv[k] = -1; lastDmRv[k] = -1; obsIfData[k] = '0;
    end
    obsIfAddr = '0; obsWdata = '0; obsWe = 1'b0; obsBe = '0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_reset_mid();
    test_both_continuous();
    test_lat1_b2b();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
